button_led_mode_controller: RTL and testbench
=============================================

// Module: button_led_mode_controller
// PURPOSE
//   Mode sequencer for one pushbutton and one LED. Classifies each press of an
//   already-synchronized pushbutton as SHORT or LONG by hold time.
//   - SHORT steps the LED mode OFF -> ON -> BLINK -> OFF.
//   - LONG forces OFF.
//   Sits between the synchronized button input and the board LED. Also exports
//   mode and one-cycle event pulses for status logic.
// PARAMETERS
//   LONG_CYCLES  8  consecutive high samples that make a press LONG; legal range >= 2
//   BLINK_HALF   4  cycles per LED half-period in BLINK; legal range >= 1
// PORTS
//   clk          in   1  single clock; all state updates on posedge
//   reset        in   1  asynchronous, active-low; 0 clears all state immediately
//   button       in   1  pushbutton, already synchronized to clk; 1 = pressed
//   led          out  1  registered LED drive
//   mode         out  2  registered: 0=OFF 1=ON 2=BLINK (3 unused)
//   short_pulse  out  1  high for exactly 1 cycle per SHORT press
//   long_pulse   out  1  high for exactly 1 cycle per LONG press
// BEHAVIOUR
//   Reset values (reset==0):
//     led=0, mode=0, short_pulse=0, long_pulse=0, hold_cnt=0, blink_cnt=0.
//     button_prev=1, so a button held through reset release is not a press.
//     It must be released and pressed again.
//   Edge detect:
//     rise = button & ~button_prev
//     fall = ~button & button_prev
//     button_prev <= button on every edge.
//   Hold counter:
//     Width $clog2(LONG_CYCLES+1); saturates at LONG_CYCLES.
//     Edge with rise: hold_cnt <= 1.
//     Edge with button & button_prev and hold_cnt < LONG_CYCLES:
//       hold_cnt <= hold_cnt+1.
//       If hold_cnt+1 == LONG_CYCLES, that edge is the LONG event.
//     Edge with fall: hold_cnt <= 0.
//       If hold_cnt < LONG_CYCLES, that edge is the SHORT event.
//       A fall after a LONG event produces no event.
//   Event timing:
//     Events take effect on the edge where they are sampled.
//     short_pulse/long_pulse are high in the following cycle only.
//     A 1-cycle press (rise then fall on the next edge) is SHORT.
//     SHORT and LONG never occur on the same edge.
//   Mode FSM:
//     SHORT: OFF->ON, ON->BLINK, BLINK->OFF.
//     LONG: any state -> OFF (OFF stays OFF; long_pulse still fires).
//     mode==3 is illegal: go to OFF on the next edge, with no pulses.
//   LED:
//     OFF: led=0. ON: led=1. Both are updated on the same edge as the mode change.
//     On entering BLINK: led <= 1, blink_cnt <= 0.
//     In BLINK on each edge:
//       if blink_cnt == BLINK_HALF-1: blink_cnt <= 0, led <= ~led
//       else: blink_cnt++.
//     Result: led high BLINK_HALF cycles, then low BLINK_HALF cycles, repeating.
//     Leaving BLINK: blink_cnt <= 0.
//   Reset mid-operation:
//     An in-progress hold or blink is abandoned with no pulse.
//     Outputs go to reset values asynchronously.
// TESTING (LONG_CYCLES=8, BLINK_HALF=4)
//   1. Reset low then high, button=0; hold button high 3 cycles, release
//      -> short_pulse one cycle after fall edge, mode=1, led=1.
//   2. From ON, repeat the 3-cycle press -> mode=2.
//      led=1 for 4 cycles, 0 for 4 cycles, repeating over >=3 periods.
//   3. From BLINK, 1-cycle press -> short_pulse once, mode=0, led=0,
//      blink_cnt idle.
//   4. From ON, hold button 20 cycles
//      -> long_pulse one cycle after 8th consecutive high sample, mode=0, led=0.
//      The release gives no short_pulse.
//   5. Hold 7 cycles then release -> SHORT.
//      Hold exactly 8 cycles then release -> LONG only, with no SHORT on release.
//   6. In BLINK with button held, pull reset low for 2 cycles, release reset
//      while button stays high -> all outputs 0 and no pulse.
//      Release then press for 2 cycles -> mode=1.

Source files
------------

// File: rtl/button_led_mode_controller.sv
// Classifies presses of a synchronized pushbutton as SHORT or LONG by hold time.
// SHORT steps the LED mode OFF -> ON -> BLINK -> OFF, and LONG forces OFF.
module button_led_mode_controller #(
  parameter int LONG_CYCLES = 8,
  parameter int BLINK_HALF  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       button,
  output logic       led,
  output logic [1:0] mode,
  output logic       short_pulse,
  output logic       long_pulse
);

  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_ILL   = 2'd3
  } mode_e;

  logic          r_button_prev;
  logic [HW-1:0] r_hold_cnt;
  mode_e         r_mode;
  logic          r_led;
  logic [BW-1:0] r_blink_cnt;
  logic          r_short_pulse;
  logic          r_long_pulse;

  logic          w_rise, w_fall, w_held, w_tracking;
  logic          w_short_evt, w_long_evt;
  mode_e         w_mode_nxt;
  logic          w_led_nxt;
  logic [BW-1:0] w_blink_nxt;
  logic          w_short_nxt, w_long_nxt;

  assign w_rise     = button & ~r_button_prev;
  assign w_fall     = ~button & r_button_prev;
  assign w_held     = button & r_button_prev;
  // A zero count means no press is in progress (e.g. button held through reset),
  // so such a hold can neither count up nor produce an event on release.
  assign w_tracking = (r_hold_cnt != '0);

  assign w_long_evt  = w_held & w_tracking & (r_hold_cnt == HW'(LONG_CYCLES - 1));
  assign w_short_evt = w_fall & w_tracking & (r_hold_cnt < HW'(LONG_CYCLES));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_button_prev <= 1'b1;
      r_hold_cnt    <= '0;
    end else begin
      r_button_prev <= button;
      if (w_rise)
        r_hold_cnt <= HW'(1);
      else if (w_held && w_tracking && (r_hold_cnt < HW'(LONG_CYCLES)))
        r_hold_cnt <= r_hold_cnt + HW'(1);
      else if (w_fall)
        r_hold_cnt <= '0;
    end
  end

  // Mode FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mode        <= MODE_OFF;
      r_led         <= 1'b0;
      r_blink_cnt   <= '0;
      r_short_pulse <= 1'b0;
      r_long_pulse  <= 1'b0;
    end else begin
      r_mode        <= w_mode_nxt;
      r_led         <= w_led_nxt;
      r_blink_cnt   <= w_blink_nxt;
      r_short_pulse <= w_short_nxt;
      r_long_pulse  <= w_long_nxt;
    end
  end

  // Mode FSM: next state
  always_comb begin
    w_mode_nxt = r_mode;
    case (r_mode)
      MODE_OFF:   if (w_short_evt) w_mode_nxt = MODE_ON;
      MODE_ON:    if (w_long_evt) w_mode_nxt = MODE_OFF;
                  else if (w_short_evt) w_mode_nxt = MODE_BLINK;
      MODE_BLINK: if (w_long_evt || w_short_evt) w_mode_nxt = MODE_OFF;
      default:    w_mode_nxt = MODE_OFF;
    endcase
  end

  // Mode FSM: registered outputs
  always_comb begin
    w_led_nxt   = 1'b0;
    w_blink_nxt = '0;
    w_short_nxt = w_short_evt & (r_mode != MODE_ILL);
    w_long_nxt  = w_long_evt & (r_mode != MODE_ILL);
    case (w_mode_nxt)
      MODE_ON: w_led_nxt = 1'b1;
      MODE_BLINK: begin
        if (r_mode != MODE_BLINK) begin
          w_led_nxt   = 1'b1;
          w_blink_nxt = '0;
        end else if (r_blink_cnt == BW'(BLINK_HALF - 1)) begin
          w_led_nxt   = ~r_led;
          w_blink_nxt = '0;
        end else begin
          w_led_nxt   = r_led;
          w_blink_nxt = r_blink_cnt + BW'(1);
        end
      end
      default: begin
        w_led_nxt   = 1'b0;
        w_blink_nxt = '0;
      end
    endcase
  end

  assign led         = r_led;
  assign mode        = r_mode;
  assign short_pulse = r_short_pulse;
  assign long_pulse  = r_long_pulse;

endmodule

// File: tb/tb_button_led_mode_controller.sv
// Scoreboard bench: driver pushes the model's expected outputs after each edge,
// a negedge monitor pops and compares them against the DUT.
module tb_button_led_mode_controller;

  localparam int LC = 8;
  localparam int BH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       button = 1'b0;
  logic       led;
  logic [1:0] mode;
  logic       short_pulse, long_pulse;

  button_led_mode_controller #(.LONG_CYCLES(LC), .BLINK_HALF(BH)) dut (
    .clk(clk), .reset(reset), .button(button), .led(led), .mode(mode),
    .short_pulse(short_pulse), .long_pulse(long_pulse)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] mode;
    logic       led;
    logic       sp;
    logic       lp;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model: press length in samples, mode as 0/1/2, blink phase from elapsed cycles
  int m_mode, m_run, m_bcyc;
  bit m_prev, m_armed;

  task automatic model_reset();
    m_mode = 0; m_run = 0; m_bcyc = 0; m_prev = 1'b1; m_armed = 1'b0;
  endtask

  task automatic step(input bit b);
    exp_t e;
    bit   sh, lg;
    int   old;
    button = b;
    @(posedge clk);
    #1;
    sh = 1'b0; lg = 1'b0;
    if (b && !m_prev) begin
      m_armed = 1'b1; m_run = 1;
    end else if (b && m_prev && m_armed) begin
      if (m_run < LC) begin
        m_run++;
        if (m_run == LC) lg = 1'b1;
      end
    end else if (!b && m_prev) begin
      if (m_armed && m_run < LC) sh = 1'b1;
      m_armed = 1'b0; m_run = 0;
    end
    m_prev = b;
    old = m_mode;
    if (lg) m_mode = 0;
    else if (sh) m_mode = (m_mode + 1) % 3;
    if (m_mode == 2) m_bcyc = (old == 2) ? m_bcyc + 1 : 0;
    e.mode = 2'(m_mode);
    e.led  = (m_mode == 1) || (m_mode == 2 && ((m_bcyc / BH) % 2 == 0));
    e.sp   = sh;
    e.lp   = lg;
    q.push_back(e);
  endtask

  task automatic press(input int n);
    for (int i = 0; i < n; i++) step(1'b1);
    step(1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0);
  endtask

  task automatic check_zero(input string name);
    checks++;
    if ({mode, led, short_pulse, long_pulse} !== 5'b0) begin
      failures++;
      $display("FAIL %s: got mode=%0d led=%0b sp=%0b lp=%0b, want all 0",
               name, mode, led, short_pulse, long_pulse);
    end
  endtask

  // Called just after a posedge; waits for the monitor to drain the last entry first.
  task automatic pulse_reset(input int cycles, input string name);
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    check_zero({name, "_async"});
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      check_zero({name, "_held"});
    end
    reset = 1'b1;
    model_reset();
    check_zero({name, "_release"});
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if ({mode, led, short_pulse, long_pulse} !== e) begin
        failures++;
        $display("FAIL scoreboard t=%0t: got mode=%0d led=%0b sp=%0b lp=%0b, want mode=%0d led=%0b sp=%0b lp=%0b",
                 $time, mode, led, short_pulse, long_pulse, e.mode, e.led, e.sp, e.lp);
      end
    end
  end

  initial begin
    model_reset();
    reset  = 1'b0;
    button = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset_state");
    reset = 1'b1;
    model_reset();

    press(3); idle(2);                 // OFF -> ON
    press(3); idle(30);                // ON -> BLINK, several blink periods
    press(1); idle(3);                 // BLINK -> OFF via 1-cycle press
    press(3); press(20); idle(3);      // ON, then LONG -> OFF with silent release
    press(7); idle(2);                 // 7 samples: SHORT
    press(8); idle(2);                 // exactly 8: LONG only
    press(8); idle(2);                 // LONG while OFF still pulses

    press(2); press(2); idle(5);       // into BLINK
    for (int i = 0; i < 3; i++) step(1'b1);
    pulse_reset(2, "rst_blink");
    for (int i = 0; i < 12; i++) step(1'b1);  // held through reset: not a press
    step(1'b0);
    press(2); idle(3);                 // -> ON

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        step(1'(($urandom_range(0, 1))));
        pulse_reset($urandom_range(1, 3), "rst_rand");
      end
      press($urandom_range(1, 12));
      idle($urandom_range(0, 9));
    end

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain: got %0d entries left, want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
